// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, one registered broadcast per cycle.
// Policy: round-robin by default; define CDB_OLDEST_FIRST_EN for oldest-ROB-entry-first.
package cdb_pkg;
  localparam int NUM_ROB_ENTRIES = 8;
  localparam int ROB_W           = $clog2(NUM_ROB_ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_entry_idx;
    logic [5:0]       pd;
    logic [31:0]      data;
  } cdb_entry_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [ROB_W-1:0]       rob_head,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  cdb_entry_t [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output cdb_entry_t             cdb_out,
  output logic                   cdb_valid
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       hold_valid;
  cdb_entry_t [NUM_REQ-1:0] hold_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     grant_any;
  logic [PTR_W-1:0]         grant_idx;
  cdb_entry_t               bcast;
  cdb_entry_t               cdb_q;

`ifdef CDB_OLDEST_FIRST_EN
  // Age is distance from the ROB head; the ROB depth is a power of two so the subtract wraps.
  logic [ROB_W-1:0] age;
  logic [ROB_W-1:0] best_age;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    best_age  = '1;
    age       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = hold_data[i].rob_entry_idx - rob_head;
      if (hold_valid[i] && (!grant_any || age < best_age)) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
        best_age  = age;
      end
    end
  end
`else
  localparam int CW = PTR_W + 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_nxt;
  logic [CW-1:0]    cand;
  logic             unused_rob_head;

  assign unused_rob_head = ^rob_head;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_any && hold_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign rr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
    bcast       = hold_data[grant_idx];
    bcast.valid = 1'b1;
  end

  // A granted slot frees up on the same edge, so it can be refilled without a bubble.
  assign req_ready = {NUM_REQ{!flush}} & (~hold_valid | grant);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      cdb_q      <= '0;
`ifndef CDB_OLDEST_FIRST_EN
      rr_ptr     <= '0;
`endif
    end else if (flush) begin
      hold_valid  <= '0;
      cdb_q.valid <= 1'b0;
    end else begin
      hold_valid <= (hold_valid & ~grant) | (req_valid & req_ready);
      if (grant_any) begin
        cdb_q <= bcast;
`ifndef CDB_OLDEST_FIRST_EN
        rr_ptr <= rr_nxt;
`endif
      end else begin
        cdb_q.valid <= 1'b0;
      end
    end
  end

  // NOTE: payload storage has no reset; hold_valid alone decides whether a slot's contents matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) hold_data[i] <= req_data[i];
    end
  end

  assign cdb_out   = cdb_q;
  assign cdb_valid = cdb_q.valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a slot-level model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [ROB_W-1:0]     rob_head = '0;
  logic [N-1:0]         req_valid = '0;
  cdb_entry_t [N-1:0]   req_data = '0;
  logic [N-1:0]         req_ready;
  cdb_entry_t           cdb_out;
  logic                 cdb_valid;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rob_head  (rob_head),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_out   (cdb_out),
    .cdb_valid (cdb_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a set of occupied slots and the broadcast expected after the last edge.
  bit         m_valid[N];
  cdb_entry_t m_data[N];
  int         m_ptr;
  bit         e_valid;
  cdb_entry_t e_out;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_ptr   = 0;
    e_valid = 1'b0;
    e_out   = '0;
  endtask

  function automatic int m_pick(input logic [ROB_W-1:0] head);
    int best = -1;
`ifdef CDB_OLDEST_FIRST_EN
    int best_age = NUM_ROB_ENTRIES;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        int age = ((int'(m_data[i].rob_entry_idx) - int'(head)) % NUM_ROB_ENTRIES
                   + NUM_ROB_ENTRIES) % NUM_ROB_ENTRIES;
        if (age < best_age) begin
          best_age = age;
          best     = i;
        end
      end
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      int idx = (m_ptr + k) % N;
      if (m_valid[idx]) best = idx;
    end
    if (head == '1) best = best;  // head is irrelevant to round-robin
`endif
    return best;
  endfunction

  function automatic cdb_entry_t mk(input int idx, input int pd, input logic [31:0] data);
    cdb_entry_t e;
    e.valid         = 1'b1;
    e.rob_entry_idx = ROB_W'(idx);
    e.pd            = 6'(pd);
    e.data          = data;
    return e;
  endfunction

  task automatic check_out();
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, e_valid});
    if (e_valid) check("cdb_out", 64'(cdb_out), 64'(e_out));
    else         check("cdb_out.valid", {63'd0, cdb_out.valid}, 64'd0);
  endtask

  // Called at a falling edge: drive, check ready, advance model, then check outputs at the next falling edge.
  task automatic cycle(input logic fl, input logic [N-1:0] v, input cdb_entry_t [N-1:0] d,
                       input logic [ROB_W-1:0] head);
    int           g;
    logic [N-1:0] exp_rdy;
    flush     = fl;
    req_valid = v;
    req_data  = d;
    rob_head  = head;
    #1;
    g = m_pick(head);
    for (int i = 0; i < N; i++) exp_rdy[i] = !fl && (!m_valid[i] || g == i);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      e_valid = 1'b0;
    end else begin
      if (g >= 0) begin
        e_out       = m_data[g];
        e_out.valid = 1'b1;
        e_valid     = 1'b1;
        m_valid[g]  = 1'b0;
        m_ptr       = (g + 1) % N;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && exp_rdy[i]) begin
          m_valid[i] = 1'b1;
          m_data[i]  = d[i];
        end
      end
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input logic [ROB_W-1:0] head);
    cycle(1'b0, '0, '0, head);
  endtask

  cdb_entry_t [N-1:0] dv;

  initial begin
    model_reset();
    #2;
    check("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_cdb_out", 64'(cdb_out), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'h1f);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef CDB_OLDEST_FIRST_EN
    // All five slots contend from rr_ptr=0: grants in slot order.
    dv = '0;
    for (int i = 0; i < N; i++) dv[i] = mk(i, 10 + i, 32'hA000 + 32'(i));
    cycle(1'b0, 5'b11111, dv, '0);
    for (int i = 0; i < N; i++) begin
      idle('0);
      check("contend_pd", 64'(cdb_out.pd), 64'(10 + i));
    end
    // rr_ptr has wrapped to 0, so slot 0 beats slot 4.
    dv = '0;
    dv[0] = mk(0, 20, 32'h20);
    dv[4] = mk(4, 24, 32'h24);
    cycle(1'b0, 5'b10001, dv, '0);
    idle('0);
    check("wrap_first", 64'(cdb_out.pd), 64'd20);
    idle('0);
    check("wrap_second", 64'(cdb_out.pd), 64'd24);
`endif

    // Single request on slot 2.
    dv = '0;
    dv[2] = mk(3, 7, 32'hCAFE);
    cycle(1'b0, 5'b00100, dv, '0);
    idle('0);
    check("single_valid", {63'd0, cdb_valid}, 64'd1);
    check("single_pd", 64'(cdb_out.pd), 64'd7);

    // Back-to-back stream from requester 1.
    for (int j = 0; j < 8; j++) begin
      dv = '0;
      dv[1] = mk(j, 30 + j, 32'(j));
      cycle(1'b0, 5'b00010, dv, '0);
      check("b2b_ready", {63'd0, req_ready[1]}, 64'd1);
      if (j > 0) check("b2b_pd", 64'(cdb_out.pd), 64'(30 + j - 1));
    end
    idle('0);
    check("b2b_last", 64'(cdb_out.pd), 64'd37);
    idle('0);

    // Flush with three slots occupied.
    dv = '0;
    for (int i = 0; i < 3; i++) dv[i] = mk(i, 40 + i, 32'h40);
    cycle(1'b0, 5'b00111, dv, '0);
    cycle(1'b1, 5'b11111, dv, '0);
    check("flush_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    idle('0);
    check("post_flush_idle", {63'd0, cdb_valid}, 64'd0);

`ifdef CDB_OLDEST_FIRST_EN
    // Head at 6: ROB idx 7 is age 1, idx 1 is age 3.
    dv = '0;
    dv[0] = mk(1, 50, 32'h50);
    dv[3] = mk(7, 53, 32'h53);
    cycle(1'b0, 5'b01001, dv, 3'd6);
    idle(3'd6);
    check("oldest_first", 64'(cdb_out.pd), 64'd53);
    idle(3'd6);
    check("oldest_second", 64'(cdb_out.pd), 64'd50);
`endif

    // Reset asserted while a broadcast is live and another slot is still held.
    dv = '0;
    dv[0] = mk(0, 60, 32'h60);
    dv[3] = mk(3, 63, 32'h63);
    cycle(1'b0, 5'b01001, dv, '0);
    idle('0);
    check("pre_reset_valid", {63'd0, cdb_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    check("midrst_cdb_out", 64'(cdb_out), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'h1f);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle('0);
    idle('0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic fl;
      fl = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++) dv[i] = mk($urandom_range(NUM_ROB_ENTRIES - 1), $urandom_range(63), $urandom);
      cycle(fl, N'($urandom), dv, ROB_W'($urandom));
    end
    for (int c = 0; c < N + 1; c++) idle('0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
